// File: rtl/accumulate_sequencer_pkg.sv
// Shared arithmetic package: data width and sequencer state encodings.
// Latency: n/a (constants only).
// Backpressure: n/a.
package accumulate_sequencer_pkg;

    localparam int DATA_W = 16;

    // Binary state encodings; kept as plain 2-bit constants so older
    // blocks that compare raw state values keep working.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_ADD   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/sixteen_bit_ripple_carry_adder.sv
// 16-bit ripple-carry adder built from a chain of full-adder cells.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   a, b  - 16-bit operands
//   cin   - carry into bit 0
//   s     - 16-bit sum (modulo 2^16)
//   cout  - carry out of bit 15
module sixteen_bit_ripple_carry_adder
    import accumulate_sequencer_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] s,
    output logic              cout
);

    logic [DATA_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DATA_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[DATA_W];

endmodule

// File: rtl/accumulate_sequencer.sv
// Accumulates 'count' 16-bit operands into a registered sum with sticky carry flag.
// Latency: 2 cycles per operand (capture, then add); done 1 cycle after the final add.
// Backpressure: din_ready only in ACCUM; the block waits indefinitely for din_valid.
//
// Ports:
//   clk, rst          - clock; asynchronous active-high reset
//   start, count      - begin a run of 'count' operands (honoured only in IDLE/DONE)
//   din, din_valid    - operand stream; transfers when din_valid && din_ready
//   din_ready         - high in ACCUM only
//   sum, ovf          - running/final sum and sticky carry-out flag
//   busy, done        - busy in ACCUM/ADD, done throughout DONE
module accumulate_sequencer
    import accumulate_sequencer_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  count,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [DATA_W-1:0] sum,
    output logic              ovf,
    output logic              busy,
    output logic              done
);

    logic [1:0]        state;
    logic [CNT_W-1:0]  remaining;
    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] add_s;
    logic              add_cout;

    sixteen_bit_ripple_carry_adder u_adder (
        .a    (sum),
        .b    (operand),
        .cin  (1'b0),
        .s    (add_s),
        .cout (add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            sum       <= '0;
            ovf       <= 1'b0;
            remaining <= '0;
            operand   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        sum <= '0;
                        ovf <= 1'b0;
                        if (count != '0) begin
                            remaining <= count;
                            state     <= ST_ACCUM;
                        end else begin
                            // Zero-length run completes immediately with result 0.
                            state <= ST_DONE;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (din_valid) begin
                        operand   <= din;
                        remaining <= remaining - CNT_W'(1);
                        state     <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    sum <= add_s;
                    ovf <= ovf | add_cout;
                    // remaining was already decremented on capture.
                    state <= (remaining != '0) ? ST_ACCUM : ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Decoded straight from state so reset clears them without waiting for a clock.
    assign din_ready = (state == ST_ACCUM);
    assign busy      = (state == ST_ACCUM) || (state == ST_ADD);
    assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_accumulate_sequencer.sv
module tb_accumulate_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  count;
    logic [15:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [15:0] sum;
    logic        ovf;
    logic        busy;
    logic        done;

    int compared   = 0;
    int mismatched = 0;

    accumulate_sequencer #(.CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .count     (count),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .sum       (sum),
        .ovf       (ovf),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        count     = 4'd0;
        din       = 16'h0000;
        din_valid = 1'b0;
        #2;
        check("rst_sum",   sum,       16'h0000);
        check("rst_ovf",   ovf,       1'b0);
        check("rst_busy",  busy,      1'b0);
        check("rst_done",  done,      1'b0);
        check("rst_ready", din_ready, 1'b0);
        step(); step();
        rst = 1'b0;
        step();
        check("idle_busy", busy, 1'b0);

        // Basic: 1 + 2 + 3, din_valid held high.
        start = 1'b1; count = 4'd3; din = 16'h0001; din_valid = 1'b1;
        step();                                   // E0 -> ACCUM
        start = 1'b0;
        check("basic_busy",  busy,      1'b1);
        check("basic_ready", din_ready, 1'b1);
        step();                                   // E1 capture 1 -> ADD
        check("basic_ready_add", din_ready, 1'b0);
        din = 16'h0002;
        step();                                   // E2 sum=1
        check("basic_sum1", sum, 16'h0001);
        step();                                   // E3 capture 2
        din = 16'h0003;
        step();                                   // E4 sum=3
        check("basic_sum3", sum, 16'h0003);
        step();                                   // E5 capture 3
        check("basic_done_early", done, 1'b0);
        step();                                   // E6 sum=6 -> DONE
        check("basic_done", done, 1'b1);
        check("basic_sum",  sum,  16'h0006);
        check("basic_ovf",  ovf,  1'b0);
        check("basic_busy_end", busy, 1'b0);
        step(); step();                           // din_valid high in DONE is ignored
        check("done_ignore_din", sum, 16'h0006);

        // Wrap: 0xFFFF + 0x0002.
        start = 1'b1; count = 4'd2; din = 16'hFFFF; din_valid = 1'b1;
        step();
        start = 1'b0;
        step();
        din = 16'h0002;
        step();
        check("wrap_sum1", sum, 16'hFFFF);
        check("wrap_ovf1", ovf, 1'b0);
        step(); step();
        check("wrap_done", done, 1'b1);
        check("wrap_sum",  sum,  16'h0001);
        check("wrap_ovf",  ovf,  1'b1);
        din_valid = 1'b0;
        step(); step();
        check("wrap_hold_sum", sum, 16'h0001);
        check("wrap_hold_ovf", ovf, 1'b1);

        // Zero-length run: done next cycle, sum and ovf cleared.
        start = 1'b1; count = 4'd0;
        step();
        start = 1'b0;
        check("zero_done", done, 1'b1);
        check("zero_sum",  sum,  16'h0000);
        check("zero_ovf",  ovf,  1'b0);
        check("zero_busy", busy, 1'b0);

        // Stall: 0x1234, five idle cycles, then 0x0001.
        start = 1'b1; count = 4'd2; din = 16'h1234; din_valid = 1'b1;
        step();
        start = 1'b0;
        step();                                   // capture 0x1234
        din_valid = 1'b0; din = 16'h0001;
        step();                                   // sum=0x1234 -> ACCUM
        repeat (5) step();
        check("stall_sum",   sum,       16'h1234);
        check("stall_ready", din_ready, 1'b1);
        check("stall_busy",  busy,      1'b1);
        din_valid = 1'b1;
        step();                                   // capture 0x0001
        din_valid = 1'b0;
        step();                                   // -> DONE
        check("stall_done", done, 1'b1);
        check("stall_sum_final", sum, 16'h1235);
        check("stall_ovf", ovf, 1'b0);

        // start held during ACCUM/ADD with count=1 must not restart the run.
        start = 1'b1; count = 4'd2; din = 16'h0005; din_valid = 1'b1;
        step();                                   // E0 -> ACCUM
        count = 4'd1;                             // start stays high
        step();                                   // E1 capture 5
        din = 16'h0007;
        step();                                   // E2 sum=5
        start = 1'b0;
        check("restart_sum1", sum,  16'h0005);
        check("restart_busy", busy, 1'b1);
        step(); step();
        check("restart_done", done, 1'b1);
        check("restart_sum",  sum,  16'h000C);

        // Asynchronous reset mid-ACCUM discards the partial result.
        start = 1'b1; count = 4'd3; din = 16'h0009; din_valid = 1'b1;
        step();
        start = 1'b0;
        step();
        step();                                   // sum=9, back in ACCUM
        din_valid = 1'b0;
        check("pre_rst_sum", sum, 16'h0009);
        rst = 1'b1;
        #1;
        check("arst_sum",   sum,       16'h0000);
        check("arst_ovf",   ovf,       1'b0);
        check("arst_done",  done,      1'b0);
        check("arst_busy",  busy,      1'b0);
        check("arst_ready", din_ready, 1'b0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_done", done, 1'b0);
        start = 1'b1; count = 4'd1; din = 16'h0004; din_valid = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        check("post_rst_run_done", done, 1'b1);
        check("post_rst_run_sum",  sum,  16'h0004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
